controle_turnos: RTL and testbench
==================================

Name: controle_turnos

Overview:
Turn scheduler for the battleship execution datapath (ExecutandoJogo).
- Enables the shot-entry block for the active human player, or generates a CPU shot from `posicao_rnd` in player-vs-CPU mode.
- Forwards each shot to the board lookup with a valid/response handshake.
- Keeps both players' remaining-piece counts, alternates turns and declares the winner.
- Sits between the shot-entry block, the two board memories and the LED/display logic.

Parameters:
- N_PECAS, 11: pieces per player at game start (fits 4 bits).
- CPU_ESPERA, 4: cycles the CPU "thinks" before firing, so its turn is visible on the LEDs.
- TIRO_EXTRA, 1: 1 = a hit grants the same player another shot; 0 = turn always alternates.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; starts (or restarts from FIM) a game.
- mode  in  1  1 = player vs player, 0 = player vs CPU; sampled only on start.
- posicao_rnd  in  4  pseudo-random coordinate source for the CPU.
- ready  in  1  one-cycle pulse from shot entry: coord_tiroX/Y are valid.
- coord_tiroX  in  4  human shot X.
- coord_tiroY  in  4  human shot Y.
- resp_valid  in  1  board lookup result valid (one-cycle pulse).
- acertou_tiro  in  1  hit flag, qualified by resp_valid.
- enable  out  1  enables shot entry (human turn only).
- jogador  out  1  active player: 0 = P1, 1 = P2/CPU.
- tiro_valid  out  1  shot request to the board of player ~jogador.
- tiro_x  out  4  shot X, stable while tiro_valid.
- tiro_y  out  4  shot Y, stable while tiro_valid.
- qtd_P1  out  4  P1 pieces remaining.
- qtd_P2  out  4  P2 pieces remaining.
- fim_jogo  out  1  game over.
- vencedor  out  2  00 none, 01 P1, 10 P2.
- LEDG  out  8  all ones while P1 has the turn, else 0.
- LEDR  out  8  all ones while P2/CPU has the turn, else 0.

Behaviour:
Reset (async, reset=0):
- State IDLE. enable=0, jogador=0, tiro_valid=0, tiro_x=tiro_y=0.
- qtd_P1=qtd_P2=N_PECAS. fim_jogo=0, vencedor=00, LEDG=LEDR=0.
- Reset mid-game aborts immediately, including a pending handshake.

States:
- IDLE: on start, latch mode_r=mode, load both counts with N_PECAS, set jogador=0, go to TURNO.
- TURNO: if jogador=1 and mode_r=0, go to CPU_ESPERA with counter=CPU_ESPERA-1. Otherwise assert enable; on ready, latch coord_tiroX/Y into tiro_x/tiro_y, drop enable in the next cycle, go to CONSULTA. A ready pulse in any other state is ignored.
- CPU_ESPERA: decrement the counter each cycle. At 0, latch tiro_x=posicao_rnd and go to CPU_Y.
- CPU_Y: latch tiro_y=posicao_rnd (second sample, one cycle later), go to CONSULTA.
- CONSULTA: tiro_valid=1, held with tiro_x/y stable until resp_valid. On resp_valid, tiro_valid drops the following cycle; register acertou_tiro; go to ATUALIZA. A resp_valid with tiro_valid=0 is ignored.
- ATUALIZA (one cycle):
  - On a hit, decrement the opponent's count (jogador=0 → qtd_P2, jogador=1 → qtd_P1), saturating at 0.
  - If the decremented count equals 0, go to FIM.
  - Else if hit and TIRO_EXTRA=1, go to TURNO with the same jogador.
  - Else toggle jogador and go to TURNO.
- FIM: fim_jogo=1, vencedor = jogador+1 encoded as 01/10, enable=0, LEDs frozen showing the winner. start returns to IDLE handling (reload counts, clear fim_jogo/vencedor) in the same cycle.

Other rules:
- LEDG/LEDR are registered decodes of jogador; both 0 in IDLE.
- start outside IDLE/FIM is ignored.
- Human shot latency: ready at edge n → tiro_valid high at edge n+1.

Decomposition:
- Package `batalha_pkg`: state encoding (IDLE, TURNO, CPU_ESPERA, CPU_Y, CONSULTA, ATUALIZA, FIM), player constants P1=0 / P2=1, vencedor codes, coordinate width 4.
- Natural sub-module `contador_pecas`: a loadable 4-bit saturating down-counter with a zero flag, instantiated twice (P1, P2).

Test Plan:
1. PvP miss: start (mode=1); ready with X=2, Y=1 → tiro_valid=1, tiro_x=2, tiro_y=1. resp_valid with acertou_tiro=0 → jogador goes 0→1, LEDR=FF, counts stay 11/11.
2. Hit with extra shot: P1 shot; resp_valid with acertou_tiro=1 → qtd_P2=10, jogador stays 0, enable reasserted in TURNO.
3. CPU turn: mode=0, P1 misses. Expect enable=0 for CPU_ESPERA cycles. With posicao_rnd=5 then 9 → tiro_x=5, tiro_y=9, tiro_valid=1.
4. Win: 11 consecutive P1 hits → qtd_P2=0, fim_jogo=1, vencedor=01. Further ready/resp_valid pulses change nothing. start → counts 11/11, fim_jogo=0.
5. Handshake hold: delay resp_valid 7 cycles after tiro_valid → tiro_valid and tiro_x/y stay stable all 7 cycles. A stray ready in CONSULTA is ignored.
6. Async reset: drop reset mid-CONSULTA, between clock edges → tiro_valid=0, state IDLE, counts=11 immediately with no clock edge.

Source files
------------

// File: rtl/batalha_pkg.sv
// Shared types and constants for the battleship turn scheduler.
package batalha_pkg;
    localparam int COORD_W = 4;
    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURNO,
        S_CPU_ESPERA,
        S_CPU_Y,
        S_CONSULTA,
        S_ATUALIZA,
        S_FIM
    } estado_t;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    localparam logic [1:0] VENC_NENHUM = 2'b00;
    localparam logic [1:0] VENC_P1     = 2'b01;
    localparam logic [1:0] VENC_P2     = 2'b10;

    function automatic logic [1:0] cod_vencedor(input logic j);
        return (j == P2) ? VENC_P2 : VENC_P1;
    endfunction
endpackage

// File: rtl/controle_turnos_if.sv
// Shot-entry and board-lookup handshakes seen by the turn scheduler.
interface controle_turnos_if;
    import batalha_pkg::*;

    logic   enable;
    logic   ready;
    coord_t coord_tiroX;
    coord_t coord_tiroY;
    logic   tiro_valid;
    coord_t tiro_x;
    coord_t tiro_y;
    logic   resp_valid;
    logic   acertou_tiro;

    modport master (
        output enable, tiro_valid, tiro_x, tiro_y,
        input  ready, coord_tiroX, coord_tiroY, resp_valid, acertou_tiro
    );
    modport slave (
        input  enable, tiro_valid, tiro_x, tiro_y,
        output ready, coord_tiroX, coord_tiroY, resp_valid, acertou_tiro
    );
endinterface

// File: rtl/contador_pecas.sv
// Loadable 4-bit saturating down-counter of a player's remaining pieces.
module contador_pecas #(
    parameter logic [3:0] N_PECAS = 4'd11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       dec,
    output logic [3:0] qtd,
    output logic       zero
);
    logic [3:0] qtd_q, qtd_d;

    always_comb begin
        qtd_d = qtd_q;
        if (load)
            qtd_d = N_PECAS;
        else if (dec && qtd_q != 4'd0)
            qtd_d = qtd_q - 4'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) qtd_q <= N_PECAS;
        else        qtd_q <= qtd_d;
    end

    assign qtd  = qtd_q;
    assign zero = (qtd_q == 4'd0);
endmodule

// File: rtl/controle_turnos.sv
// Turn scheduler: routes human/CPU shots to the board lookup, tracks pieces, declares the winner.
module controle_turnos
    import batalha_pkg::*;
#(
    parameter int N_PECAS    = 11,
    parameter int CPU_ESPERA = 4,
    parameter bit TIRO_EXTRA = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  coord_t              posicao_rnd,
    controle_turnos_if.master   bus,
    output logic                jogador,
    output logic [3:0]          qtd_P1,
    output logic [3:0]          qtd_P2,
    output logic                fim_jogo,
    output logic [1:0]          vencedor,
    output logic [7:0]          LEDG,
    output logic [7:0]          LEDR
);
    localparam logic [7:0] ESPERA_INI = 8'(CPU_ESPERA - 1);

    estado_t    state_q, state_d;
    logic       jogador_q, jogador_d;
    logic       mode_r_q, mode_r_d;
    logic       hit_q, hit_d;
    coord_t     tiro_x_q, tiro_x_d;
    coord_t     tiro_y_q, tiro_y_d;
    logic [7:0] espera_q, espera_d;
    logic [7:0] ledg_q, ledg_d;
    logic [7:0] ledr_q, ledr_d;

    logic carrega, dec_p1, dec_p2, zero_p1, zero_p2;
    logic vez_cpu, acaba;

    assign vez_cpu = (jogador_q == P2) && !mode_r_q;
    assign dec_p1  = (state_q == S_ATUALIZA) && hit_q && (jogador_q == P2);
    assign dec_p2  = (state_q == S_ATUALIZA) && hit_q && (jogador_q == P1);
    // Decide end of game on the pre-decrement count, so FIM follows ATUALIZA directly.
    assign acaba   = hit_q && ((jogador_q == P1) ? (zero_p2 || qtd_P2 == 4'd1)
                                                 : (zero_p1 || qtd_P1 == 4'd1));

    contador_pecas #(.N_PECAS(4'(N_PECAS))) u_pecas_p1 (
        .clk(clk), .reset(reset), .load(carrega), .dec(dec_p1), .qtd(qtd_P1), .zero(zero_p1)
    );
    contador_pecas #(.N_PECAS(4'(N_PECAS))) u_pecas_p2 (
        .clk(clk), .reset(reset), .load(carrega), .dec(dec_p2), .qtd(qtd_P2), .zero(zero_p2)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            jogador_q <= P1;
            mode_r_q  <= 1'b0;
            hit_q     <= 1'b0;
            tiro_x_q  <= '0;
            tiro_y_q  <= '0;
            espera_q  <= '0;
            ledg_q    <= '0;
            ledr_q    <= '0;
        end else begin
            state_q   <= state_d;
            jogador_q <= jogador_d;
            mode_r_q  <= mode_r_d;
            hit_q     <= hit_d;
            tiro_x_q  <= tiro_x_d;
            tiro_y_q  <= tiro_y_d;
            espera_q  <= espera_d;
            ledg_q    <= ledg_d;
            ledr_q    <= ledr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        jogador_d = jogador_q;
        mode_r_d  = mode_r_q;
        hit_d     = hit_q;
        tiro_x_d  = tiro_x_q;
        tiro_y_d  = tiro_y_q;
        espera_d  = espera_q;
        carrega   = 1'b0;
        case (state_q)
            S_IDLE, S_FIM: begin
                if (start) begin
                    mode_r_d  = mode;
                    jogador_d = P1;
                    carrega   = 1'b1;
                    state_d   = S_TURNO;
                end
            end
            S_TURNO: begin
                if (vez_cpu) begin
                    espera_d = ESPERA_INI;
                    state_d  = S_CPU_ESPERA;
                end else if (bus.ready) begin
                    tiro_x_d = bus.coord_tiroX;
                    tiro_y_d = bus.coord_tiroY;
                    state_d  = S_CONSULTA;
                end
            end
            S_CPU_ESPERA: begin
                if (espera_q == 8'd0) begin
                    tiro_x_d = posicao_rnd;
                    state_d  = S_CPU_Y;
                end else begin
                    espera_d = espera_q - 8'd1;
                end
            end
            S_CPU_Y: begin
                tiro_y_d = posicao_rnd;
                state_d  = S_CONSULTA;
            end
            S_CONSULTA: begin
                if (bus.resp_valid) begin
                    hit_d   = bus.acertou_tiro;
                    state_d = S_ATUALIZA;
                end
            end
            S_ATUALIZA: begin
                if (acaba)
                    state_d = S_FIM;
                else if (hit_q && TIRO_EXTRA)
                    state_d = S_TURNO;
                else begin
                    jogador_d = ~jogador_q;
                    state_d   = S_TURNO;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // LEDs follow the next player so they switch on the same edge as jogador.
        ledg_d = (state_d != S_IDLE && jogador_d == P1) ? 8'hFF : 8'h00;
        ledr_d = (state_d != S_IDLE && jogador_d == P2) ? 8'hFF : 8'h00;
    end

    always_comb begin
        bus.enable     = (state_q == S_TURNO) && !vez_cpu;
        bus.tiro_valid = (state_q == S_CONSULTA);
        bus.tiro_x     = tiro_x_q;
        bus.tiro_y     = tiro_y_q;
        fim_jogo       = (state_q == S_FIM);
        vencedor       = (state_q == S_FIM) ? cod_vencedor(jogador_q) : VENC_NENHUM;
        jogador        = jogador_q;
        LEDG           = ledg_q;
        LEDR           = ledr_q;
    end
endmodule

// File: tb/tb_controle_turnos.sv
// Bench for controle_turnos: vector table, corner-case sequences and random games vs a game model.
module tb_controle_turnos;
    import batalha_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] posicao_rnd = 4'd0;
    logic       jogador;
    logic [3:0] qtd_P1, qtd_P2;
    logic       fim_jogo;
    logic [1:0] vencedor;
    logic [7:0] LEDG, LEDR;

    controle_turnos_if bus();

    controle_turnos dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .posicao_rnd(posicao_rnd),
        .bus(bus), .jogador(jogador), .qtd_P1(qtd_P1), .qtd_P2(qtd_P2),
        .fim_jogo(fim_jogo), .vencedor(vencedor), .LEDG(LEDG), .LEDR(LEDR)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] x, y;
        logic       hit;
        logic       exp_j;
        logic [3:0] exp_p1, exp_p2;
    } vec_t;
    vec_t tab[6];

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nome, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; bus.ready = 1'b0; bus.resp_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    // mode is flipped after the pulse: the DUT must keep the value seen on start
    task automatic start_game(input logic m);
        mode = m; start = 1'b1;
        tick();
        start = 1'b0; mode = ~m;
    endtask

    task automatic shoot(input logic [3:0] x, input logic [3:0] y);
        bus.coord_tiroX = x; bus.coord_tiroY = y; bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0;
        bus.coord_tiroX = ~x; bus.coord_tiroY = ~y;
    endtask

    task automatic respond(input logic h);
        bus.acertou_tiro = h; bus.resp_valid = 1'b1;
        tick();
        bus.resp_valid = 1'b0; bus.acertou_tiro = ~h;
        tick();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        int n, opp, mc[2];
        logic m, mj, mfim, h, en_seen;
        logic [3:0] r, rx, ry;

        tab[0] = '{4'd2,  4'd1,  1'b0, 1'b1, 4'd11, 4'd11};
        tab[1] = '{4'd3,  4'd3,  1'b1, 1'b1, 4'd10, 4'd11};
        tab[2] = '{4'd0,  4'd0,  1'b0, 1'b0, 4'd10, 4'd11};
        tab[3] = '{4'd15, 4'd15, 1'b1, 1'b0, 4'd10, 4'd10};
        tab[4] = '{4'd9,  4'd4,  1'b1, 1'b0, 4'd10, 4'd9};
        tab[5] = '{4'd1,  4'd2,  1'b0, 1'b1, 4'd10, 4'd9};

        bus.ready = 1'b0; bus.resp_valid = 1'b0; bus.acertou_tiro = 1'b0;
        bus.coord_tiroX = 4'd0; bus.coord_tiroY = 4'd0;

        // reset state, held in reset
        tick();
        chk("rst_enable", 32'(bus.enable), 0);
        chk("rst_jogador", 32'(jogador), 0);
        chk("rst_valid", 32'(bus.tiro_valid), 0);
        chk("rst_tiro_x", 32'(bus.tiro_x), 0);
        chk("rst_tiro_y", 32'(bus.tiro_y), 0);
        chk("rst_qtd_P1", 32'(qtd_P1), 11);
        chk("rst_qtd_P2", 32'(qtd_P2), 11);
        chk("rst_fim", 32'(fim_jogo), 0);
        chk("rst_venc", 32'(vencedor), 0);
        chk("rst_leds", 32'({LEDG, LEDR}), 0);
        reset = 1'b1;

        // ready in IDLE is ignored
        shoot(4'd6, 4'd6);
        tick();
        chk("idle_ready_valid", 32'(bus.tiro_valid), 0);
        chk("idle_enable", 32'(bus.enable), 0);

        // PvP vector table
        start_game(1'b1);
        chk("pvp_start_LEDG", 32'(LEDG), 32'hFF);
        for (int i = 0; i < 6; i++) begin
            chk("tab_enable", 32'(bus.enable), 1);
            shoot(tab[i].x, tab[i].y);
            chk("tab_valid", 32'(bus.tiro_valid), 1);
            chk("tab_enable_off", 32'(bus.enable), 0);
            chk("tab_tiro_x", 32'(bus.tiro_x), 32'(tab[i].x));
            chk("tab_tiro_y", 32'(bus.tiro_y), 32'(tab[i].y));
            respond(tab[i].hit);
            chk("tab_jogador", 32'(jogador), 32'(tab[i].exp_j));
            chk("tab_qtd_P1", 32'(qtd_P1), 32'(tab[i].exp_p1));
            chk("tab_qtd_P2", 32'(qtd_P2), 32'(tab[i].exp_p2));
            chk("tab_LEDG", 32'(LEDG), tab[i].exp_j ? 32'h0 : 32'hFF);
            chk("tab_LEDR", 32'(LEDR), tab[i].exp_j ? 32'hFF : 32'h0);
            chk("tab_fim", 32'(fim_jogo), 0);
        end

        // CPU turn: 4 thinking cycles, x then y sampled one cycle apart
        do_reset();
        start_game(1'b0);
        shoot(4'd8, 4'd8);
        posicao_rnd = 4'd5;
        respond(1'b0);
        chk("cpu_jogador", 32'(jogador), 1);
        chk("cpu_LEDR", 32'(LEDR), 32'hFF);
        chk("cpu_enable0", 32'(bus.enable), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("cpu_wait_enable", 32'(bus.enable), 0);
            chk("cpu_wait_valid", 32'(bus.tiro_valid), 0);
        end
        tick();
        chk("cpu_y_valid", 32'(bus.tiro_valid), 0);
        posicao_rnd = 4'd9;
        tick();
        chk("cpu_valid", 32'(bus.tiro_valid), 1);
        chk("cpu_tiro_x", 32'(bus.tiro_x), 5);
        chk("cpu_tiro_y", 32'(bus.tiro_y), 9);
        chk("cpu_enable_consulta", 32'(bus.enable), 0);
        respond(1'b0);
        chk("cpu_back_P1", 32'(jogador), 0);
        chk("cpu_back_enable", 32'(bus.enable), 1);

        // win with 11 consecutive P1 hits, then FIM is inert
        do_reset();
        start_game(1'b1);
        for (int k = 0; k < 11; k++) begin
            shoot(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            respond(1'b1);
            chk("win_qtd_P2", 32'(qtd_P2), 32'(10 - k));
        end
        chk("win_fim", 32'(fim_jogo), 1);
        chk("win_venc", 32'(vencedor), 1);
        chk("win_enable", 32'(bus.enable), 0);
        chk("win_LEDG", 32'(LEDG), 32'hFF);
        chk("win_jogador", 32'(jogador), 0);
        bus.ready = 1'b1; tick(); bus.ready = 1'b0;
        bus.resp_valid = 1'b1; bus.acertou_tiro = 1'b1; tick(); bus.resp_valid = 1'b0;
        tick();
        chk("fim_hold_fim", 32'(fim_jogo), 1);
        chk("fim_hold_valid", 32'(bus.tiro_valid), 0);
        chk("fim_hold_qtd", 32'({qtd_P1, qtd_P2}), 32'h0B0);
        chk("fim_hold_LEDG", 32'(LEDG), 32'hFF);
        start_game(1'b1);
        chk("restart_qtd", 32'({qtd_P1, qtd_P2}), 32'hBB);
        chk("restart_fim", 32'(fim_jogo), 0);
        chk("restart_venc", 32'(vencedor), 0);
        chk("restart_enable", 32'(bus.enable), 1);

        // handshake held 7 cycles, stray ready ignored
        shoot(4'd7, 4'd3);
        for (int k = 0; k < 7; k++) begin
            if (k == 2) begin
                bus.coord_tiroX = 4'd1; bus.coord_tiroY = 4'd1; bus.ready = 1'b1;
            end
            tick();
            bus.ready = 1'b0;
            chk("hold_valid", 32'(bus.tiro_valid), 1);
            chk("hold_xy", 32'({bus.tiro_x, bus.tiro_y}), 32'h73);
        end
        bus.resp_valid = 1'b1; bus.acertou_tiro = 1'b1;
        tick();
        bus.resp_valid = 1'b0;
        chk("hold_drop", 32'(bus.tiro_valid), 0);
        tick();
        chk("extra_shot_jogador", 32'(jogador), 0);
        chk("extra_shot_qtd_P2", 32'(qtd_P2), 10);
        chk("extra_shot_enable", 32'(bus.enable), 1);

        // async reset mid-CONSULTA, between edges
        shoot(4'd4, 4'd4);
        chk("pre_rst_valid", 32'(bus.tiro_valid), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.tiro_valid), 0);
        chk("arst_qtd", 32'({qtd_P1, qtd_P2}), 32'hBB);
        chk("arst_enable", 32'(bus.enable), 0);
        chk("arst_leds", 32'({LEDG, LEDR}), 0);
        tick();
        reset = 1'b1;

        // random games against a turn-level model
        for (int g = 0; g < 3; g++) begin
            do_reset();
            m = (g == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            start_game(m);
            mj = 1'b0; mfim = 1'b0; mc[0] = 11; mc[1] = 11;
            for (int t = 0; t < 300 && !mfim; t++) begin
                if (mj && !m) begin
                    r = 4'($urandom_range(0, 15));
                    posicao_rnd = r;
                    n = 0; en_seen = 1'b0;
                    while (bus.tiro_valid !== 1'b1 && n < 20) begin
                        if (bus.enable !== 1'b0) en_seen = 1'b1;
                        tick();
                        n++;
                    end
                    chk("rnd_cpu_timeout", 32'(n < 20), 1);
                    chk("rnd_cpu_enable", 32'(en_seen), 0);
                    chk("rnd_cpu_xy", 32'({bus.tiro_x, bus.tiro_y}), 32'({r, r}));
                end else begin
                    chk("rnd_enable", 32'(bus.enable), 1);
                    rx = 4'($urandom_range(0, 15));
                    ry = 4'($urandom_range(0, 15));
                    shoot(rx, ry);
                    chk("rnd_xy", 32'({bus.tiro_x, bus.tiro_y}), 32'({rx, ry}));
                end
                repeat ($urandom_range(0, 3)) tick();
                chk("rnd_valid", 32'(bus.tiro_valid), 1);
                h = ($urandom_range(0, 9) < 6);
                respond(h);
                opp = mj ? 0 : 1;
                if (h) begin
                    mc[opp] = mc[opp] - 1;
                    if (mc[opp] == 0) mfim = 1'b1;
                end else begin
                    mj = ~mj;
                end
                chk("rnd_jogador", 32'(jogador), 32'(mj));
                chk("rnd_qtd_P1", 32'(qtd_P1), 32'(mc[0]));
                chk("rnd_qtd_P2", 32'(qtd_P2), 32'(mc[1]));
                chk("rnd_fim", 32'(fim_jogo), 32'(mfim));
                chk("rnd_venc", 32'(vencedor), mfim ? (mj ? 32'd2 : 32'd1) : 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
